note_player: RTL and testbench
==============================

# note_player

Playback sequencer downstream of the note memory. On a start request it rewinds the memory read pointer, then fetches stored note codes one at a time through the memory's read_en / output_ready interface. Each note is played as a square wave on the buzzer for a fixed duration, followed by a silent gap, until the memory reports exhaustion or a stop is requested.

## Interface
- DATA_WIDTH, 8, note code width; must match the note memory data width
- NOTE_CYC, 25_000_000, clk cycles each note sounds (≥1)
- GAP_CYC, 2_500_000, silent clk cycles after each note (≥1)
- TONE_SHIFT, 0, right shift applied to base half-periods (simulation speed-up)
- clk  in  1  system clock, 100 MHz nominal
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  one-cycle play request; ignored unless idle
- stop  in  1  abort playback; wins over every other event
- mem_data  in  DATA_WIDTH  note code from memory data_out
- mem_ready  in  1  memory output_ready
- mem_read_en  out  1  one-cycle fetch request to memory
- mem_read_rst  out  1  one-cycle read-pointer rewind to memory
- note_out  out  DATA_WIDTH  code currently sounding; 0 when idle or in a gap
- buzzer  out  1  square-wave audio output
- playing  out  1  high from REWIND until return to IDLE
- done  out  1  one-cycle pulse when playback ends (exhaustion or stop)

## Operation
- Note code: bits[3:0] are the note (0 = rest, 1..7 = do..si, 8..15 = rest). Bits[5:4] are the octave (0 low, 1 mid, 2 high, 3 → rest). Upper bits are ignored.
- Mid-octave base half-periods in cycles, C4..B4: 191110, 170265, 151685, 143172, 127551, 113636, 101239.
- Half-period = base >> TONE_SHIFT. For low octave, additionally <<1; for high octave, >>1. The half-period register is 20 bits and is latched once at note start.
- A rest holds buzzer at 0 but still consumes NOTE_CYC and GAP_CYC.
- FSM states:
  - IDLE → REWIND on start (with no stop).
  - REWIND: mem_read_rst=1 for one cycle → FETCH.
  - FETCH: mem_read_en=1 for one cycle → LATCH.
  - LATCH: samples mem_ready and mem_data. If mem_ready=1: latch the code, clear the counters → PLAY. If mem_ready=0 → FINISH.
  - PLAY: lasts NOTE_CYC cycles. The tone counter toggles buzzer each half-period cycles, starting from buzzer=0 → GAP.
  - GAP: lasts GAP_CYC cycles; buzzer=0, note_out=0 → FETCH.
  - FINISH: done=1 for one cycle; buzzer and note_out cleared → IDLE.
- stop in any non-IDLE state → FINISH on the next edge. stop in IDLE does nothing, and done stays 0.
- Reset at any time → IDLE, all counters cleared. No memory request is issued during or after reset until the next start.
- The duration counter is 32 bits, compared against NOTE_CYC-1 and GAP_CYC-1. It is never allowed to wrap.

## Timing
- Reset values: mem_read_en=0, mem_read_rst=0, note_out=0, buzzer=0, playing=0, done=0.
- All outputs are registered.
- start sampled at edge t: mem_read_rst is high during cycle t+1, mem_read_en during t+2, LATCH occupies t+3, PLAY begins t+4.
- The memory registers its output one edge after read_en, so LATCH always sits exactly one cycle after FETCH.
- note_out is valid for the whole of PLAY.
- The first buzzer rise occurs half-period cycles after PLAY entry.
- Per-note period = NOTE_CYC + GAP_CYC + 2 cycles (FETCH, LATCH).
- Empty memory: the first LATCH sees mem_ready=0, and done pulses at t+4.
- start and stop in the same cycle while IDLE: stop wins, FSM stays in IDLE.

## Test plan
- Parameters for all scenarios: NOTE_CYC=20, GAP_CYC=4, TONE_SHIFT=10.
- Reset mid-PLAY: deassert rst_n for 1 cycle → next cycle all outputs are 0 and the state is IDLE. A later start replays from the first note.
- Memory holds {0x00, 0x16, 0x21}, start pulse:
  - mem_read_rst at +1, mem_read_en at +2.
  - Rest note: buzzer stays 0 for 20 cycles.
  - 0x16 (mid A): half-period 110, so no toggle within 20 cycles; note_out=0x16.
  - 0x21 (high do): half-period 93.
  - Then done pulses once and playing falls.
- With NOTE_CYC=400, code 0x16 → buzzer toggles at cycles 110, 220, 330 of PLAY. Code 0x06 (low A) → toggles at 220 only.
- Empty memory, start → mem_read_rst, mem_read_en, then done exactly 4 cycles after start; buzzer never toggles.
- stop asserted during the third cycle of GAP → done the following cycle, no further mem_read_en. Code 0x36 plays silently but holds note_out for 20 cycles.
- start pulsed while playing → ignored: no second mem_read_rst, sequence unchanged.

Source files
------------

// File: rtl/note_player.sv
// note_player: playback sequencer behind the note memory.
// Rewinds the memory, fetches one note code at a time and plays it as a
// square wave for NOTE_CYC cycles, followed by a GAP_CYC silent gap.
// Playback ends when the memory runs out or stop is asserted.
//
// Memory handshake: mem_read_en is a one-cycle request. The memory answers
// on the following cycle with mem_ready/mem_data, which are sampled while
// in LATCH. mem_ready=0 at that point means no further notes.
// All outputs are registered and derived from the next state, so each one
// changes on the same edge that enters the corresponding state.
module note_player #(
  parameter int DATA_WIDTH = 8,
  parameter int NOTE_CYC   = 25_000_000,
  parameter int GAP_CYC    = 2_500_000,
  parameter int TONE_SHIFT = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  mem_ready,
  output logic                  mem_read_en,
  output logic                  mem_read_rst,
  output logic [DATA_WIDTH-1:0] note_out,
  output logic                  buzzer,
  output logic                  playing,
  output logic                  done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REWIND = 3'd1,
    S_FETCH  = 3'd2,
    S_LATCH  = 3'd3,
    S_PLAY   = 3'd4,
    S_GAP    = 3'd5,
    S_FINISH = 3'd6
  } state_t;

  localparam logic [31:0] NOTE_LAST = 32'(NOTE_CYC - 1);
  localparam logic [31:0] GAP_LAST  = 32'(GAP_CYC - 1);

  state_t state;
  state_t next_state;

  logic [31:0] dur_cnt;
  logic [19:0] tone_cnt;
  logic [19:0] half_q;
  logic [19:0] base_period;
  logic [19:0] scaled_period;
  logic [19:0] half_d;
  logic        tone_hit;
  logic        stay_play;

  logic                  read_en_d;
  logic                  read_rst_d;
  logic [DATA_WIDTH-1:0] note_d;
  logic                  buzzer_d;
  logic                  playing_d;
  logic                  done_d;

  // Decode the fetched code into a half-period; 0 marks a rest (silent).
  always_comb begin
    base_period = 20'd0;
    case (mem_data[3:0])
      4'd1:    base_period = 20'd191110;
      4'd2:    base_period = 20'd170265;
      4'd3:    base_period = 20'd151685;
      4'd4:    base_period = 20'd143172;
      4'd5:    base_period = 20'd127551;
      4'd6:    base_period = 20'd113636;
      4'd7:    base_period = 20'd101239;
      default: base_period = 20'd0;
    endcase
    scaled_period = base_period >> TONE_SHIFT;
    case (mem_data[5:4])
      2'd0:    half_d = scaled_period << 1;
      2'd1:    half_d = scaled_period;
      2'd2:    half_d = scaled_period >> 1;
      default: half_d = 20'd0;
    endcase
  end

  assign tone_hit  = (half_q != 20'd0) && (tone_cnt == half_q - 20'd1);
  assign stay_play = (state == S_PLAY) && (next_state == S_PLAY);

  // Next-state logic; stop overrides everything outside IDLE and FINISH.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (start && !stop) next_state = S_REWIND;
      S_REWIND: next_state = S_FETCH;
      S_FETCH:  next_state = S_LATCH;
      S_LATCH:  next_state = mem_ready ? S_PLAY : S_FINISH;
      S_PLAY:   if (dur_cnt >= NOTE_LAST) next_state = S_GAP;
      S_GAP:    if (dur_cnt >= GAP_LAST) next_state = S_FETCH;
      S_FINISH: next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
    if (stop && state != S_IDLE && state != S_FINISH) next_state = S_FINISH;
  end

  // Output values for the coming cycle, keyed on the state being entered.
  always_comb begin
    read_rst_d = (next_state == S_REWIND);
    read_en_d  = (next_state == S_FETCH);
    done_d     = (next_state == S_FINISH);
    playing_d  = (next_state != S_IDLE);
    note_d     = '0;
    buzzer_d   = 1'b0;
    if (next_state == S_PLAY) note_d = (state == S_LATCH) ? mem_data : note_out;
    if (stay_play) buzzer_d = tone_hit ? ~buzzer : buzzer;
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      dur_cnt      <= 32'd0;
      tone_cnt     <= 20'd0;
      half_q       <= 20'd0;
      mem_read_en  <= 1'b0;
      mem_read_rst <= 1'b0;
      note_out     <= '0;
      buzzer       <= 1'b0;
      playing      <= 1'b0;
      done         <= 1'b0;
    end else begin
      state <= next_state;
      // Duration counter restarts on every state change and saturates.
      if (next_state != state || state == S_IDLE) dur_cnt <= 32'd0;
      else if (dur_cnt != 32'hFFFF_FFFF)          dur_cnt <= dur_cnt + 32'd1;
      if (stay_play) tone_cnt <= tone_hit ? 20'd0 : tone_cnt + 20'd1;
      else           tone_cnt <= 20'd0;
      if (state == S_LATCH) half_q <= half_d;
      mem_read_en  <= read_en_d;
      mem_read_rst <= read_rst_d;
      note_out     <= note_d;
      buzzer       <= buzzer_d;
      playing      <= playing_d;
      done         <= done_d;
    end
  end

endmodule

// File: tb/tb_note_player.sv
// Bench for note_player: two instances (short and long note duration),
// each with a behavioural note memory. Expected per-cycle output vectors
// {mem_read_rst, mem_read_en, playing, done, buzzer, note_out} are queued
// from the playback timeline and popped as the DUT runs.
module tb_note_player;

  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: NOTE_CYC=20
  logic          start_a = 1'b0, stop_a = 1'b0;
  logic [DW-1:0] mem_data_a = '0;
  logic          mem_ready_a = 1'b0;
  logic          read_en_a, read_rst_a, buzzer_a, playing_a, done_a;
  logic [DW-1:0] note_a;
  // Instance B: NOTE_CYC=400
  logic          start_b = 1'b0, stop_b = 1'b0;
  logic [DW-1:0] mem_data_b = '0;
  logic          mem_ready_b = 1'b0;
  logic          read_en_b, read_rst_b, buzzer_b, playing_b, done_b;
  logic [DW-1:0] note_b;

  note_player #(.DATA_WIDTH(DW), .NOTE_CYC(20), .GAP_CYC(4), .TONE_SHIFT(10)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .stop(stop_a),
    .mem_data(mem_data_a), .mem_ready(mem_ready_a),
    .mem_read_en(read_en_a), .mem_read_rst(read_rst_a),
    .note_out(note_a), .buzzer(buzzer_a), .playing(playing_a), .done(done_a)
  );

  note_player #(.DATA_WIDTH(DW), .NOTE_CYC(400), .GAP_CYC(4), .TONE_SHIFT(10)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .stop(stop_b),
    .mem_data(mem_data_b), .mem_ready(mem_ready_b),
    .mem_read_en(read_en_b), .mem_read_rst(read_rst_b),
    .note_out(note_b), .buzzer(buzzer_b), .playing(playing_b), .done(done_b)
  );

  // Note memory models: output registered one edge after read_en.
  logic [DW-1:0] mem_a [0:7];
  logic [DW-1:0] mem_b [0:7];
  int n_a = 0, n_b = 0, ptr_a = 0, ptr_b = 0;

  always @(posedge clk) begin
    if (read_rst_a) ptr_a <= 0;
    else if (read_en_a) begin
      if (ptr_a < n_a) begin
        mem_data_a <= mem_a[ptr_a]; mem_ready_a <= 1'b1; ptr_a <= ptr_a + 1;
      end else mem_ready_a <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (read_rst_b) ptr_b <= 0;
    else if (read_en_b) begin
      if (ptr_b < n_b) begin
        mem_data_b <= mem_b[ptr_b]; mem_ready_b <= 1'b1; ptr_b <= ptr_b + 1;
      end else mem_ready_b <= 1'b0;
    end
  end

  // Scoreboard
  logic [12:0] exp_q[$];
  logic [DW-1:0] seq [0:7];
  int seq_n = 0;
  int errors = 0;
  int checks = 0;

  function automatic logic [12:0] vec(input logic r, input logic e, input logic p,
                                      input logic d, input logic b, input logic [7:0] n);
    return {r, e, p, d, b, n};
  endfunction

  // Half-periods for the codes used here, worked out by hand at TONE_SHIFT=10.
  function automatic int half_of(input logic [7:0] code);
    case (code)
      8'h16:   return 110;  // 113636>>10
      8'h21:   return 93;   // (191110>>10)>>1
      8'h06:   return 220;  // (113636>>10)<<1
      default: return 0;    // rests
    endcase
  endfunction

  task automatic gen_trace(input int n_cyc, input int g_cyc);
    int h;
    exp_q.push_back(vec(1, 0, 1, 0, 0, 8'h00));
    exp_q.push_back(vec(0, 1, 1, 0, 0, 8'h00));
    exp_q.push_back(vec(0, 0, 1, 0, 0, 8'h00));
    for (int c = 0; c < seq_n; c++) begin
      h = half_of(seq[c]);
      for (int k = 0; k < n_cyc; k++)
        exp_q.push_back(vec(0, 0, 1, 0, (h != 0) ? 1'((k / h) % 2) : 1'b0, seq[c]));
      for (int k = 0; k < g_cyc; k++) exp_q.push_back(vec(0, 0, 1, 0, 0, 8'h00));
      exp_q.push_back(vec(0, 1, 1, 0, 0, 8'h00));
      exp_q.push_back(vec(0, 0, 1, 0, 0, 8'h00));
    end
    exp_q.push_back(vec(0, 0, 1, 1, 0, 8'h00));
    exp_q.push_back(vec(0, 0, 0, 0, 0, 8'h00));
    exp_q.push_back(vec(0, 0, 0, 0, 0, 8'h00));
  endtask

  task automatic set_note(input bit sel, input int i, input logic [7:0] code);
    seq[i] = code;
    if (sel) mem_b[i] = code; else mem_a[i] = code;
  endtask

  // Pulse start (with optional stop/restart/reset events keyed on the
  // observed cycle index) and compare every cycle against the queue.
  task automatic run_check(input bit sel, input int stop_at, input int start_at,
                           input int rst_at, input string name);
    logic [12:0] obs, exp_v;
    int i = 0;
    @(negedge clk);
    if (sel) begin start_b = 1'b1; stop_b = (stop_at == 0); end
    else     begin start_a = 1'b1; stop_a = (stop_at == 0); end
    while (exp_q.size() > 0 && i < 5000) begin
      @(posedge clk); #1;
      i++;
      if (sel) begin start_b = (i == start_at); stop_b = (i == stop_at); end
      else     begin start_a = (i == start_at); stop_a = (i == stop_at); end
      rst_n = !(i == rst_at);
      obs = sel ? {read_rst_b, read_en_b, playing_b, done_b, buzzer_b, note_b}
                : {read_rst_a, read_en_a, playing_a, done_a, buzzer_a, note_a};
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL %s cycle %0d: got rst/en/play/done/buz=%b note=%h, want %b note=%h",
                 name, i, obs[12:8], obs[7:0], exp_v[12:8], exp_v[7:0]);
      end
    end
    start_a = 1'b0; stop_a = 1'b0; start_b = 1'b0; stop_b = 1'b0; rst_n = 1'b1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s timeout: %0d entries left, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({read_rst_a, read_en_a, playing_a, done_a, buzzer_a, note_a} !== 13'd0 ||
          {read_rst_b, read_en_b, playing_b, done_b, buzzer_b, note_b} !== 13'd0) begin
        errors++;
        $display("FAIL reset_values: a=%h b=%h, want 0",
                 {read_rst_a, read_en_a, playing_a, done_a, buzzer_a, note_a},
                 {read_rst_b, read_en_b, playing_b, done_b, buzzer_b, note_b});
      end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_sequence;
    set_note(0, 0, 8'h00); set_note(0, 1, 8'h16); set_note(0, 2, 8'h21);
    n_a = 3; seq_n = 3;
    gen_trace(20, 4);
    run_check(0, -1, -1, -1, "sequence");
  endtask

  task automatic test_empty;
    n_a = 0; seq_n = 0;
    gen_trace(20, 4);
    run_check(0, -1, -1, -1, "empty");
  endtask

  task automatic test_start_stop_idle;
    for (int k = 0; k < 4; k++) exp_q.push_back(13'd0);
    run_check(0, 0, -1, -1, "start_stop_idle");
  endtask

  task automatic test_stop_in_gap;
    set_note(0, 0, 8'h36); set_note(0, 1, 8'h16);
    n_a = 2; seq_n = 2;
    gen_trace(20, 4);
    // Keep REWIND, FETCH, LATCH, 20 PLAY and 3 GAP cycles; stop during the third.
    while (exp_q.size() > 26) void'(exp_q.pop_back());
    exp_q.push_back(vec(0, 0, 1, 1, 0, 8'h00));
    for (int k = 0; k < 4; k++) exp_q.push_back(13'd0);
    run_check(0, 26, -1, -1, "stop_in_gap");
  endtask

  task automatic test_start_while_playing;
    set_note(0, 0, 8'h16);
    n_a = 1; seq_n = 1;
    gen_trace(20, 4);
    run_check(0, -1, 10, -1, "start_while_playing");
  endtask

  task automatic test_reset_mid_play;
    set_note(0, 0, 8'h21); set_note(0, 1, 8'h16);
    n_a = 2; seq_n = 2;
    gen_trace(20, 4);
    while (exp_q.size() > 15) void'(exp_q.pop_back());
    for (int k = 0; k < 3; k++) exp_q.push_back(13'd0);
    run_check(0, -1, -1, 15, "reset_mid_play");
    gen_trace(20, 4);
    run_check(0, -1, -1, -1, "replay_after_reset");
  endtask

  task automatic test_tone_long;
    set_note(1, 0, 8'h16); set_note(1, 1, 8'h06);
    n_b = 2; seq_n = 2;
    gen_trace(400, 4);
    run_check(1, -1, -1, -1, "tone_long");
  endtask

  initial begin
    test_reset;
    test_sequence;
    test_empty;
    test_start_stop_idle;
    test_stop_in_gap;
    test_start_while_playing;
    test_reset_mid_play;
    test_tone_long;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
